// File: rtl/bp_lite_to_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_lite_to_stream_tx: serializes one buffered BedRock Lite message into   |
// | header+data stream beats with an advancing beat address.                  |
// | Header layout (MSB..LSB): {payload, size[2:0], addr, subop[3:0], type[3:0]}|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bp_lite_to_stream_tx #(
  parameter int          paddr_width_p    = 40,
  parameter int          in_data_width_p  = 512,
  parameter int          out_data_width_p = 64,
  parameter int          payload_width_p  = 16,
  parameter logic [31:0] payload_mask_p   = 32'h0,
  localparam int         hdr_width_lp     = payload_width_p + 3 + paddr_width_p + 8,
  localparam int         in_msg_width_lp  = hdr_width_lp + in_data_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [in_msg_width_lp-1:0]  in_msg_i,
  input  logic                        in_msg_v_i,
  output logic                        in_msg_ready_and_o,
  output logic [hdr_width_lp-1:0]     out_msg_header_o,
  output logic [out_data_width_p-1:0] out_msg_data_o,
  output logic                        out_msg_v_o,
  input  logic                        out_msg_ready_and_i,
  output logic                        out_msg_last_o
);

  localparam int beats_lp     = in_data_width_p / out_data_width_p;
  localparam int out_bytes_lp = out_data_width_p / 8;
  localparam int cnt_w_lp     = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 subop;
    logic [3:0]                 msg_type;
  } hdr_s;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_e;

  state_e                                    state_r, state_n;
  hdr_s                                      header_r, in_hdr, out_hdr;
  logic [beats_lp-1:0][out_data_width_p-1:0] data_r;
  logic [cnt_w_lp-1:0]                       beat_cnt_r, beat_cnt_n;
  logic [cnt_w_lp-1:0]                       last_beat_r, last_beat_n;
  logic                                      full, in_fire, out_fire;

  // Index of the final beat: non-data types and sub-beat sizes emit one beat.
  function automatic logic [cnt_w_lp-1:0] last_beat_f(input logic [3:0] t, input logic [2:0] sz);
    int n;
    if (!payload_mask_p[t]) begin
      n = 1;
    end else begin
      n = (1 << sz) / out_bytes_lp;
      if (n < 1)        n = 1;
      if (n > beats_lp) n = beats_lp;
    end
    return cnt_w_lp'(n - 1);
  endfunction

  assign in_hdr   = hdr_s'(in_msg_i[in_msg_width_lp-1 -: hdr_width_lp]);
  assign full     = (state_r == SEND);
  assign out_fire = full & out_msg_ready_and_i;
  assign in_fire  = in_msg_v_i & in_msg_ready_and_o;

  assign out_msg_v_o        = full;
  assign out_msg_last_o     = full & (beat_cnt_r == last_beat_r);
  assign in_msg_ready_and_o = reset_n_i & (~full | (out_fire & out_msg_last_o));
  assign out_msg_data_o     = data_r[beat_cnt_r];
  assign out_msg_header_o   = out_hdr;

  always_comb begin
    out_hdr      = header_r;
    out_hdr.addr = header_r.addr
                 + (paddr_width_p'(beat_cnt_r) * paddr_width_p'(out_bytes_lp));
  end

  always_comb begin
    state_n     = state_r;
    beat_cnt_n  = beat_cnt_r;
    last_beat_n = last_beat_r;
    if (out_fire) begin
      if (out_msg_last_o) state_n    = EMPTY;
      else                beat_cnt_n = beat_cnt_r + 1'b1;
    end
    if (in_fire) begin
      state_n     = SEND;
      beat_cnt_n  = '0;
      last_beat_n = last_beat_f(in_hdr.msg_type, in_hdr.size);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= EMPTY;
      beat_cnt_r  <= '0;
      last_beat_r <= '0;
    end else begin
      state_r     <= state_n;
      beat_cnt_r  <= beat_cnt_n;
      last_beat_r <= last_beat_n;
    end
  end

  // Message payload needs no reset; it is only observed while full.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      header_r <= in_hdr;
      data_r   <= in_msg_i[in_data_width_p-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_lite_to_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_lite_to_stream_tx: directed self-checking bench, 512b -> 64b beats.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_bp_lite_to_stream_tx;

  localparam int HW = 16 + 3 + 40 + 8;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [HW+DW-1:0] in_msg;
  logic            in_v;
  logic            in_ready;
  logic [HW-1:0]   out_hdr;
  logic [63:0]     out_data;
  logic            out_v;
  logic            out_ready;
  logic            out_last;

  int total = 0;
  int bad   = 0;

  bp_lite_to_stream_tx #(
    .paddr_width_p    (40),
    .in_data_width_p  (512),
    .out_data_width_p (64),
    .payload_width_p  (16),
    .payload_mask_p   (32'h0000_000A)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .in_msg_i            (in_msg),
    .in_msg_v_i          (in_v),
    .in_msg_ready_and_o  (in_ready),
    .out_msg_header_o    (out_hdr),
    .out_msg_data_o      (out_data),
    .out_msg_v_o         (out_v),
    .out_msg_ready_and_i (out_ready),
    .out_msg_last_o      (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a);
    return {16'h00A5, sz, a, 4'h3, t};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [63:0] base);
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = base + 64'(i);
    return d;
  endfunction

  // Presents a message and waits for it to be taken; returns just after the accepting edge.
  task automatic send(input logic [HW-1:0] h, input logic [DW-1:0] d);
    int k;
    in_msg = {h, d};
    in_v   = 1'b1;
    k      = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1 in_v = 1'b0;
  endtask

  // Checks n beats on consecutive cycles with ready held high, then an idle output.
  task automatic collect(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] base,
                         input logic [DW-1:0] d, input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w = d[i*64 +: 64];
      chk("beat_v", out_v, 1);
      chk("beat_hdr", out_hdr, mk_hdr(t, sz, base + 40'(i * 8)));
      chk("beat_data", out_data, w);
      chk("beat_last", out_last, (i == n - 1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("idle_after", out_v, 0);
  endtask

  initial begin
    logic [DW-1:0] da, db;
    logic [63:0]   w;
    int            b, c;
    logic          exp_last;

    rst_n     = 1'b0;
    in_v      = 1'b0;
    in_msg    = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v", out_v, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);
    chk("rel_v", out_v, 0);

    // 64B write: eight beats
    @(posedge clk);
    #1;
    da = mk_data(64'h0);
    send(mk_hdr(4'h1, 3'd6, 40'h00_8000_0000), da);
    collect(4'h1, 3'd6, 40'h00_8000_0000, da, 8);

    // read type is not in the payload mask: single beat
    @(posedge clk);
    #1;
    da = mk_data(64'h55);
    send(mk_hdr(4'h0, 3'd6, 40'h00_1234_0040), da);
    collect(4'h0, 3'd6, 40'h00_1234_0040, da, 1);

    // sub-beat write
    @(posedge clk);
    #1;
    da = '0;
    da[31:0] = 32'hDEAD_BEEF;
    send(mk_hdr(4'h1, 3'd2, 40'h00_0000_1000), da);
    collect(4'h1, 3'd2, 40'h00_0000_1000, da, 1);

    // backpressure pattern 1,0,0 repeating
    @(posedge clk);
    #1;
    da = mk_data(64'h1000);
    send(mk_hdr(4'h3, 3'd6, 40'h00_2000_0000), da);
    b = 0;
    c = 0;
    while (b < 8 && c < 40) begin
      out_ready = (c % 3 == 0);
      @(negedge clk);
      w        = da[b*64 +: 64];
      exp_last = (b == 7);
      chk("stall_v", out_v, 1);
      chk("stall_hdr", out_hdr, mk_hdr(4'h3, 3'd6, 40'h00_2000_0000 + 40'(b * 8)));
      chk("stall_data", out_data, w);
      chk("stall_last", out_last, exp_last);
      chk("stall_in_ready", in_ready, exp_last & out_ready);
      @(posedge clk);
      #1;
      if (out_ready) b++;
      c++;
    end
    chk("stall_done", b, 8);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_idle", out_v, 0);

    // back-to-back messages with valid held
    @(posedge clk);
    #1;
    da     = mk_data(64'h0);
    db     = mk_data(64'h100);
    in_msg = {mk_hdr(4'h1, 3'd6, 40'h00_8000_0000), da};
    in_v   = 1'b1;
    @(negedge clk);
    chk("b2b_accept", in_ready, 1);
    @(posedge clk);
    #1 in_msg = {mk_hdr(4'h1, 3'd6, 40'h00_9000_0000), db};
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      w = (k < 8) ? da[(k % 8)*64 +: 64] : db[(k % 8)*64 +: 64];
      chk("b2b_v", out_v, 1);
      chk("b2b_hdr", out_hdr, mk_hdr(4'h1, 3'd6, ((k < 8) ? 40'h00_8000_0000 : 40'h00_9000_0000) + 40'((k % 8) * 8)));
      chk("b2b_data", out_data, w);
      chk("b2b_last", out_last, (k % 8 == 7));
      chk("b2b_in_ready", in_ready, (k % 8 == 7));
      @(posedge clk);
      #1;
      if (k == 7) in_v = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", out_v, 0);

    // reset in the middle of a message
    @(posedge clk);
    #1;
    da = mk_data(64'h2000);
    send(mk_hdr(4'h1, 3'd6, 40'h00_4000_0000), da);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_hdr", out_hdr, mk_hdr(4'h1, 3'd6, 40'h00_4000_0000 + 40'(i * 8)));
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_v", out_v, 0);
    chk("async_last", out_last, 0);
    chk("async_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_v", out_v, 0);
    chk("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    db = mk_data(64'h3000);
    send(mk_hdr(4'h1, 3'd6, 40'h00_5000_0000), db);
    collect(4'h1, 3'd6, 40'h00_5000_0000, db, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
